// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between the execute stage (requester 0)
// and the branch/loop-address unit (requester 1).
//
// Handshakes: a command or response transfers on the rising clock edge where
// its valid and ready are both high. A requester keeps valid and its fields
// stable until that edge. It may drop valid before it is accepted. Only one
// command is in flight at a time.
//
// Optional feature: define ALU_ARB_FIXED_PRIO_EN to make requester 0 always
// win a tie. The default build uses round-robin between the two requesters.
//
// ALU_LAT (1..15) is the number of cycles the ALU inputs are held before the
// result and overflow are sampled.

module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,

  input  logic       r0_valid,
  output logic       r0_ready,
  input  logic [2:0] r0_opcode,
  input  logic [2:0] r0_funcA,
  input  logic       r0_funcB,
  input  logic [7:0] r0_in1,
  input  logic [7:0] r0_in2,
  output logic       r0_rsp_valid,
  input  logic       r0_rsp_ready,

  input  logic       r1_valid,
  output logic       r1_ready,
  input  logic [2:0] r1_opcode,
  input  logic [2:0] r1_funcA,
  input  logic       r1_funcB,
  input  logic [7:0] r1_in1,
  input  logic [7:0] r1_in2,
  output logic       r1_rsp_valid,
  input  logic       r1_rsp_ready,

  output logic [7:0] rsp_result,
  output logic       rsp_overflow,

  output logic [2:0] alu_opcode,
  output logic [2:0] alu_funcA,
  output logic       alu_funcB,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  input  logic [7:0] alu_result,
  input  logic       alu_overflow,

  output logic [1:0] dbg_state,
  output logic       dbg_last_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter is loaded with ALU_LAT-1 so BUSY lasts exactly ALU_LAT cycles.
  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  // Reset values of the command registers form the ALU "Zero" operation.
  localparam logic [2:0] ZERO_OPCODE = 3'b110;
  localparam logic [2:0] ZERO_FUNCA  = 3'b101;
  localparam logic       ZERO_FUNCB  = 1'b1;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        grant_id;
  logic        last_grant;

  logic [2:0]  cmd_opcode;
  logic [2:0]  cmd_funcA;
  logic        cmd_funcB;
  logic [7:0]  cmd_in1;
  logic [7:0]  cmd_in2;

  logic [7:0]  rsp_result_q;
  logic        rsp_overflow_q;

  logic        any_valid;
  logic        winner;
  logic        accept;
  logic        rsp_take;

  // Pick the requester to serve if a command is accepted this cycle.
  always_comb begin
    winner    = 1'b0;
    any_valid = r0_valid | r1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    winner = ~r0_valid & r1_valid;
`else
    if (r0_valid && r1_valid) begin
      winner = ~last_grant;
    end else begin
      winner = r1_valid;
    end
`endif
  end

  // Command ready is offered only in IDLE, only to the winner, never in reset.
  always_comb begin
    accept   = (state == IDLE) && any_valid && !reset;
    r0_ready = accept && (winner == 1'b0) && r0_valid;
    r1_ready = accept && (winner == 1'b1) && r1_valid;
    rsp_take = (state == RESP) && (grant_id ? r1_rsp_ready : r0_rsp_ready);
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_take) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture, latency count, result capture and grant history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_opcode     <= ZERO_OPCODE;
      cmd_funcA      <= ZERO_FUNCA;
      cmd_funcB      <= ZERO_FUNCB;
      cmd_in1        <= 8'h00;
      cmd_in2        <= 8'h00;
      cnt            <= 4'd0;
      grant_id       <= 1'b0;
      last_grant     <= 1'b1;
      rsp_result_q   <= 8'h00;
      rsp_overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant_id <= winner;
            cnt      <= CNT_LOAD;
            if (winner) begin
              cmd_opcode <= r1_opcode;
              cmd_funcA  <= r1_funcA;
              cmd_funcB  <= r1_funcB;
              cmd_in1    <= r1_in1;
              cmd_in2    <= r1_in2;
            end else begin
              cmd_opcode <= r0_opcode;
              cmd_funcA  <= r0_funcA;
              cmd_funcB  <= r0_funcB;
              cmd_in1    <= r0_in1;
              cmd_in2    <= r0_in2;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            rsp_result_q   <= alu_result;
            rsp_overflow_q <= alu_overflow;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_take) begin
            last_grant <= grant_id;
          end
        end
        default: ;
      endcase
    end
  end

  // The ALU always sees the command registers, so its inputs only move at accept.
  always_comb begin
    alu_opcode     = cmd_opcode;
    alu_funcA      = cmd_funcA;
    alu_funcB      = cmd_funcB;
    alu_in1        = cmd_in1;
    alu_in2        = cmd_in2;
    rsp_result     = rsp_result_q;
    rsp_overflow   = rsp_overflow_q;
    r0_rsp_valid   = (state == RESP) && (grant_id == 1'b0);
    r1_rsp_valid   = (state == RESP) && (grant_id == 1'b1);
    dbg_state      = state;
    dbg_last_grant = last_grant;
  end

endmodule
